mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Sits between EX/MEM and WB.
- Consumes the EX/MEM register outputs and issues loads and stores to the data memory over a req/ready handshake.
- Performs byte-lane steering, sign/zero extension and misalignment checks, and raises mem_stall while memory is busy.
- Owns the MEM/WB pipeline register (the wb_* outputs), so it has built-in stall, bubble and timeout behaviour.

Parameters:
- TIMEOUT, 16: maximum stalled cycles per access before it is aborted with bus_error (legal range 2..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- RegWrite_in  in  1  from EX/MEM
- MemRead_in  in  1  load request
- MemWrite_in  in  1  store request
- MemToReg_in  in  1  WB source select
- alu_result_in  in  32  effective address / ALU value
- rs2_data_in  in  32  store data
- rd_in  in  5  destination register
- funct3_in  in  3  access size/sign (added to EX/MEM alongside this block)
- dmem_req  out  1  memory request (combinational)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {alu_result_in[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (combinational)
- wb_RegWrite  out  1  MEM/WB register
- wb_MemToReg  out  1  MEM/WB register
- wb_alu_result  out  32  MEM/WB register
- wb_load_data  out  32  extended load data
- wb_rd  out  5  MEM/WB register
- misaligned_exc  out  1  registered 1-cycle pulse
- bus_error  out  1  registered 1-cycle pulse

Behaviour:
- Reset: all wb_* outputs, misaligned_exc and bus_error go to 0. FSM goes to IDLE and wait_cnt to 0. dmem_req=0 and mem_stall=0 while rst=1. Reset mid-access abandons the access; no WB write occurs.
- op = MemRead_in | MemWrite_in. If both are set, the load takes priority (dmem_we=0).
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- bad = op AND (illegal funct3, OR halfword with addr[0]=1, OR word with addr[1:0]!=0).
- A bad access:
  - dmem_req=0 and mem_stall=0.
  - Next edge: misaligned_exc=1, wb_RegWrite=0, other wb_* fields captured normally.
- Store lanes:
  - SB: dmem_be = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: dmem_be = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: dmem_be = 1111, wdata = rs2.
  - Loads: dmem_be = 1111.
- Load extract (little-endian): select the byte or halfword by addr[1:0] from dmem_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, WAIT.
  - IDLE:
    - dmem_req = op & ~bad.
    - If ready: zero-wait completion, mem_stall=0.
    - Else: mem_stall=1, go to WAIT, wait_cnt=0.
  - WAIT:
    - dmem_req=1. Upstream inputs are guaranteed stable because they are frozen by mem_stall.
    - If ready: completion, mem_stall=0, go to IDLE.
    - Else if wait_cnt==TIMEOUT-2: abort cycle. dmem_req forced to 0, mem_stall=0. Next edge: bus_error=1, wb_RegWrite=0. Go to IDLE.
    - Else: wait_cnt++, mem_stall=1.
  - An access therefore stalls at most TIMEOUT-1 cycles before the abort cycle.
- MEM/WB register, updated every edge:
  - mem_stall=1: loads a bubble (wb_RegWrite=0, wb_rd=0); other fields don't-care.
  - Otherwise: captures the *_in fields and the extended load data.
- A store is issued exactly once per instruction. dmem_ready is ignored when dmem_req=0.
- Non-memory instructions pass through with 1-cycle latency and never stall.

Test Plan:
- ALU op (RegWrite=1, rd=5, alu_result=0x1234), no mem -> next cycle wb_RegWrite=1, wb_rd=5, wb_alu_result=0x1234; mem_stall never asserted.
- LB at addr 0x103 with ready=1 same cycle and rdata=0x80FF_FF7F -> no stall; next cycle wb_load_data=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
- SH at addr 0x22 with rs2=0xABCD_1234, ready after 3 cycles -> dmem_be=1100, dmem_addr=0x20, dmem_wdata=0x1234_1234; mem_stall high exactly 3 cycles; wb_RegWrite=0 during the stall; exactly one cycle with req&ready.
- LW at addr 0x41 -> dmem_req never asserted, no stall, misaligned_exc pulses 1 cycle, wb_RegWrite=0.
- LW with ready held 0, TIMEOUT=4 -> mem_stall high 3 cycles, abort cycle with req=0, bus_error pulse, wb_RegWrite=0, FSM back in IDLE.
- rst asserted during WAIT -> next cycle dmem_req=0, mem_stall=0, all wb_* outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: issues data-memory loads/stores over a
// req/ready handshake, steers byte lanes, extends load data, flags misaligned
// or illegal accesses, aborts accesses that wait too long, and owns MEM/WB.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemToReg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wb_RegWrite,
    output logic        wb_MemToReg,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic [4:0]  wb_rd,
    output logic        misaligned_exc,
    output logic        bus_error
);

    // Last wait_cnt value before the access is abandoned.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 2);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        is_load, is_store, op, legal, misalign, bad, abort;
    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode the access and classify it as legal/aligned or bad.
    always_comb begin
        is_load  = MemRead_in;
        is_store = MemWrite_in & ~MemRead_in;  // a load wins when both are set
        op       = MemRead_in | MemWrite_in;
        off      = alu_result_in[1:0];
        legal    = 1'b0;
        if (is_load)
            legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010) ||
                    (funct3_in == 3'b100) || (funct3_in == 3'b101);
        else if (is_store)
            legal = (funct3_in == 3'b000) || (funct3_in == 3'b001) || (funct3_in == 3'b010);
        misalign = ((funct3_in[1:0] == 2'b01) && off[0]) ||
                   ((funct3_in[1:0] == 2'b10) && (off != 2'b00));
        bad      = op & (~legal | misalign);
    end

    // Handshake and stall: WAIT keeps requesting until ready or the abort cycle.
    always_comb begin
        abort     = (state == WAIT) && !dmem_ready && (wait_cnt == LAST_CNT);
        dmem_req  = !rst && ((state == IDLE) ? (op && !bad) : !abort);
        mem_stall = dmem_req && !dmem_ready;
        dmem_we   = is_store;
        dmem_addr = {alu_result_in[31:2], 2'b00};
    end

    // Store lane steering; loads always read the whole word.
    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = rs2_data_in;
        if (is_store) begin
            case (funct3_in[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{rs2_data_in[7:0]}};
                end
                2'b01: begin
                    dmem_be    = off[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata = {2{rs2_data_in[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = rs2_data_in;
                end
            endcase
        end
    end

    // Little-endian byte/halfword pick and sign/zero extension of read data.
    always_comb begin
        byte_sel = dmem_rdata[8*off +: 8];
        half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_in)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Access FSM: IDLE starts a wait when memory is not ready, WAIT counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                WAIT: begin
                    if (dmem_ready || abort)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, suppress writeback on bad/abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_RegWrite    <= 1'b0;
            wb_MemToReg    <= 1'b0;
            wb_alu_result  <= 32'd0;
            wb_load_data   <= 32'd0;
            wb_rd          <= 5'd0;
            misaligned_exc <= 1'b0;
            bus_error      <= 1'b0;
        end else if (mem_stall) begin
            wb_RegWrite    <= 1'b0;
            wb_rd          <= 5'd0;
            misaligned_exc <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            wb_RegWrite    <= RegWrite_in && !bad && !abort;
            wb_MemToReg    <= MemToReg_in;
            wb_alu_result  <= alu_result_in;
            wb_load_data   <= load_ext;
            wb_rd          <= rd_in;
            misaligned_exc <= bad;
            bus_error      <= abort;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table, hand sequences for the
// multi-cycle cases, and randomized traffic against a behavioural model.
module tb_mem_access_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        wb_RegWrite, wb_MemToReg;
    logic [31:0] wb_alu_result, wb_load_data;
    logic [4:0]  wb_rd;
    logic        misaligned_exc, bus_error;

    mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .MemToReg_in(MemToReg_in), .alu_result_in(alu_result_in), .rs2_data_in(rs2_data_in),
        .rd_in(rd_in), .funct3_in(funct3_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .wb_rd(wb_rd),
        .misaligned_exc(misaligned_exc), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;  // stall cycles already spent by the access currently presented

    logic        obs_req, obs_stall, obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    typedef struct {
        logic        rw, mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rdata;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_rw;
        logic [31:0] e_ld;
        logic        e_mis;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                                input logic e_req, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic e_rw, input logic [31:0] e_ld,
                                input logic e_mis);
        vec_t v;
        v.rw = rw; v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata;
        v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_rw = e_rw; v.e_ld = e_ld; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic clr();
        RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
        alu_result_in = 0; rs2_data_in = 0; rd_in = 0; funct3_in = 0;
        dmem_ready = 0; dmem_rdata = 0;
    endtask

    // One clock: check combinational outputs mid-cycle against the model,
    // then check the MEM/WB register just after the edge.
    task automatic do_cycle();
        bit ld, st, op, legal, bad, complete, abort, e_req, e_stall;
        int sz;
        int off;
        logic [31:0] bv, hv, e_ld, e_be, e_wd;
        @(negedge clk);
        ld = MemRead_in; st = MemWrite_in && !MemRead_in; op = ld || st;
        legal = 0; sz = 1;
        if (ld) begin
            case (funct3_in)
                3'd0, 3'd4: begin legal = 1; sz = 1; end
                3'd1, 3'd5: begin legal = 1; sz = 2; end
                3'd2:       begin legal = 1; sz = 4; end
                default:    legal = 0;
            endcase
        end else if (st) begin
            case (funct3_in)
                3'd0:    begin legal = 1; sz = 1; end
                3'd1:    begin legal = 1; sz = 2; end
                3'd2:    begin legal = 1; sz = 4; end
                default: legal = 0;
            endcase
        end
        bad = op && (!legal || ((alu_result_in % sz) != 0));
        complete = 0; abort = 0; e_req = 0; e_stall = 0;
        if (rst || !op || bad) begin
            e_req = 0; e_stall = 0;
        end else if (dmem_ready) begin
            e_req = 1; complete = 1;
        end else if (k == TIMEOUT - 1) begin
            abort = 1;
        end else begin
            e_req = 1; e_stall = 1;
        end
        off = int'(alu_result_in % 4);
        bv = (dmem_rdata >> (8 * off)) & 32'hFF;
        hv = (dmem_rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (funct3_in)
            3'd0:    e_ld = (bv >= 32'h80) ? (bv | 32'hFFFF_FF00) : bv;
            3'd1:    e_ld = (hv >= 32'h8000) ? (hv | 32'hFFFF_0000) : hv;
            3'd4:    e_ld = bv;
            3'd5:    e_ld = hv;
            default: e_ld = dmem_rdata;
        endcase
        case (sz)
            1:       begin e_be = 32'(1) << off; e_wd = (rs2_data_in & 32'hFF) * 32'h0101_0101; end
            2:       begin e_be = (off >= 2) ? 32'hC : 32'h3; e_wd = (rs2_data_in & 32'hFFFF) * 32'h0001_0001; end
            default: begin e_be = 32'hF; e_wd = rs2_data_in; end
        endcase
        if (ld) e_be = 32'hF;
        obs_req = dmem_req; obs_stall = mem_stall; obs_we = dmem_we;
        obs_be = dmem_be; obs_addr = dmem_addr; obs_wdata = dmem_wdata;
        chk("dmem_req", dmem_req, e_req);
        chk("mem_stall", mem_stall, e_stall);
        if (e_req) begin
            chk("dmem_we", dmem_we, st);
            chk("dmem_addr", dmem_addr, alu_result_in & 32'hFFFF_FFFC);
            chk("dmem_be", dmem_be, e_be);
            if (st) chk("dmem_wdata", dmem_wdata, e_wd);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_wb_RegWrite", wb_RegWrite, 0);
            chk("rst_wb_MemToReg", wb_MemToReg, 0);
            chk("rst_wb_alu_result", wb_alu_result, 0);
            chk("rst_wb_load_data", wb_load_data, 0);
            chk("rst_wb_rd", wb_rd, 0);
            chk("rst_misaligned", misaligned_exc, 0);
            chk("rst_bus_error", bus_error, 0);
            k = 0;
        end else if (e_stall) begin
            chk("bubble_RegWrite", wb_RegWrite, 0);
            chk("bubble_rd", wb_rd, 0);
            chk("bubble_misaligned", misaligned_exc, 0);
            chk("bubble_bus_error", bus_error, 0);
            k++;
        end else begin
            chk("wb_RegWrite", wb_RegWrite, RegWrite_in && !bad && !abort);
            chk("wb_MemToReg", wb_MemToReg, MemToReg_in);
            chk("wb_alu_result", wb_alu_result, alu_result_in);
            chk("wb_rd", wb_rd, rd_in);
            chk("misaligned_exc", misaligned_exc, bad);
            chk("bus_error", bus_error, abort);
            if (ld && complete) chk("wb_load_data", wb_load_data, e_ld);
            k = 0;
        end
    endtask

    initial begin
        vec_t vt[15];
        int stalls, hs;

        vt[0]  = mk(1, 0, 0, 3'd0, 32'h1234, 0, 0,            0, 0, 4'h0, 0,            1, 0,            0);
        vt[1]  = mk(1, 1, 0, 3'd0, 32'h103,  0, 32'h80FF_FF7F, 1, 0, 4'hF, 0,           1, 32'hFFFF_FF80, 0);
        vt[2]  = mk(1, 1, 0, 3'd4, 32'h103,  0, 32'h80FF_FF7F, 1, 0, 4'hF, 0,           1, 32'h0000_0080, 0);
        vt[3]  = mk(1, 1, 0, 3'd1, 32'h102,  0, 32'h80FF_FF7F, 1, 0, 4'hF, 0,           1, 32'hFFFF_80FF, 0);
        vt[4]  = mk(1, 1, 0, 3'd5, 32'h100,  0, 32'h80FF_FF7F, 1, 0, 4'hF, 0,           1, 32'h0000_FF7F, 0);
        vt[5]  = mk(1, 1, 0, 3'd2, 32'h44,   0, 32'h1234_5678, 1, 0, 4'hF, 0,           1, 32'h1234_5678, 0);
        vt[6]  = mk(1, 1, 0, 3'd2, 32'h41,   0, 0,             0, 0, 4'h0, 0,           0, 0,            1);
        vt[7]  = mk(0, 0, 1, 3'd0, 32'h101, 32'hA5, 0,         1, 1, 4'h2, 32'hA5A5_A5A5, 0, 0,          0);
        vt[8]  = mk(0, 0, 1, 3'd2, 32'h200, 32'hDEAD_BEEF, 0,  1, 1, 4'hF, 32'hDEAD_BEEF, 0, 0,          0);
        vt[9]  = mk(0, 0, 1, 3'd1, 32'h102, 32'hABCD_1234, 0,  1, 1, 4'hC, 32'h1234_1234, 0, 0,          0);
        vt[10] = mk(1, 1, 0, 3'd3, 32'h0,    0, 0,             0, 0, 4'h0, 0,           0, 0,            1);
        vt[11] = mk(0, 0, 1, 3'd4, 32'h0,    0, 0,             0, 0, 4'h0, 0,           0, 0,            1);
        vt[12] = mk(0, 0, 1, 3'd1, 32'h101,  0, 0,             0, 0, 4'h0, 0,           0, 0,            1);
        vt[13] = mk(1, 1, 1, 3'd0, 32'h2,    0, 32'h00FF_0000, 1, 0, 4'hF, 0,           1, 32'hFFFF_FFFF, 0);
        vt[14] = mk(1, 1, 0, 3'd1, 32'h100,  0, 32'h0000_8001, 1, 0, 4'hF, 0,           1, 32'hFFFF_8001, 0);

        clr();
        rst = 1;
        do_cycle();
        do_cycle();
        rst = 0;

        // Directed zero-wait vectors.
        for (int i = 0; i < 15; i++) begin
            clr();
            RegWrite_in = vt[i].rw; MemRead_in = vt[i].mr; MemWrite_in = vt[i].mw;
            MemToReg_in = vt[i].mr; funct3_in = vt[i].f3; alu_result_in = vt[i].addr;
            rs2_data_in = vt[i].rs2; rd_in = 5'(i + 5); dmem_rdata = vt[i].rdata; dmem_ready = 1;
            do_cycle();
            chk("tbl_req", obs_req, vt[i].e_req);
            chk("tbl_stall", obs_stall, 0);
            if (vt[i].e_req) begin
                chk("tbl_we", obs_we, vt[i].e_we);
                chk("tbl_be", obs_be, vt[i].e_be);
                if (vt[i].e_we) chk("tbl_wdata", obs_wdata, vt[i].e_wdata);
            end
            chk("tbl_wb_RegWrite", wb_RegWrite, vt[i].e_rw);
            chk("tbl_misaligned", misaligned_exc, vt[i].e_mis);
            if (vt[i].mr && !vt[i].e_mis) chk("tbl_load_data", wb_load_data, vt[i].e_ld);
        end

        // SH with three wait cycles: one handshake, three stall cycles.
        clr();
        MemWrite_in = 1; funct3_in = 3'd1; alu_result_in = 32'h22; rs2_data_in = 32'hABCD_1234;
        stalls = 0; hs = 0;
        for (int c = 0; c < 4; c++) begin
            dmem_ready = (c == 3);
            do_cycle();
            if (obs_stall) stalls++;
            if (obs_req && dmem_ready) hs++;
            if (c == 0) begin
                chk("sh_be", obs_be, 4'hC);
                chk("sh_addr", obs_addr, 32'h20);
                chk("sh_wdata", obs_wdata, 32'h1234_1234);
            end
        end
        chk("sh_stall_cycles", stalls, 3);
        chk("sh_handshakes", hs, 1);
        clr();
        dmem_ready = 1;
        do_cycle();

        // LW never ready: three stalls, abort cycle, bus_error pulse.
        clr();
        RegWrite_in = 1; MemRead_in = 1; MemToReg_in = 1; funct3_in = 3'd2;
        alu_result_in = 32'h80; rd_in = 5'd7;
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            if (obs_stall) stalls++;
        end
        chk("to_stall_cycles", stalls, 3);
        chk("to_abort_req", obs_req, 0);
        chk("to_bus_error", bus_error, 1);
        chk("to_wb_RegWrite", wb_RegWrite, 0);
        // Back in IDLE: the same access is issued afresh.
        do_cycle();
        chk("to_reissue_req", obs_req, 1);
        chk("to_reissue_stall", obs_stall, 1);

        // Reset while waiting abandons the access.
        rst = 1;
        do_cycle();
        chk("rst_wait_RegWrite", wb_RegWrite, 0);
        chk("rst_wait_rd", wb_rd, 0);
        rst = 0;
        clr();
        do_cycle();
        chk("post_rst_req", obs_req, 0);
        chk("post_rst_stall", obs_stall, 0);
        // Wait counter must start over after reset.
        RegWrite_in = 1; MemRead_in = 1; funct3_in = 3'd2; alu_result_in = 32'h84; rd_in = 5'd9;
        stalls = 0;
        for (int c = 0; c < 4; c++) begin
            do_cycle();
            if (obs_stall) stalls++;
        end
        chk("post_rst_stalls", stalls, 3);
        chk("post_rst_bus_error", bus_error, 1);

        // Randomized traffic; inputs held while the model says we are stalled.
        clr();
        for (int n = 0; n < 400; n++) begin
            if (k == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                RegWrite_in = 1'($urandom);
                MemRead_in  = (r >= 3 && r <= 5) || r == 9;
                MemWrite_in = r >= 6;
                MemToReg_in = 1'($urandom);
                funct3_in   = 3'($urandom_range(0, 7));
                alu_result_in = $urandom;
                rs2_data_in = $urandom;
                rd_in       = 5'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            dmem_ready = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom;
            do_cycle();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
